// File: rtl/viterbi_decoder_top.sv
// Hard-decision Viterbi decoder, rate 1/2, K=3, generators 7/5 (octal).
// Re-decodes the held input frame on a free-running 18-cycle schedule.
module viterbi_decoder_top #(
   parameter int FRAME_SYMS = 8,
   parameter int PM_W       = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [2*FRAME_SYMS-1:0] data_in,
   output logic [FRAME_SYMS-1:0]   data_out
);

   localparam int IW = $clog2(FRAME_SYMS);
   localparam logic [PM_W-1:0] PM_MAX  = '1;
   localparam logic [IW-1:0]   LAST_IX = IW'(FRAME_SYMS - 1);

   typedef enum logic [1:0] {
      LOAD,
      ACS,
      TRACEBACK,
      OUTPUT
   } state_t;

   state_t                  state;
   logic [2*FRAME_SYMS-1:0] frame;
   logic [PM_W-1:0]         pm     [4];
   logic [PM_W-1:0]         pm_nxt [4];
   logic [FRAME_SYMS-1:0]   surv   [4];
   logic [IW-1:0]           idx;
   logic [1:0]              tb_state;
   logic [FRAME_SYMS-1:0]   dec;

   logic [1:0]      rx;
   logic [1:0]      ns;
   logic [1:0]      e0;
   logic [1:0]      e1;
   logic [PM_W-1:0] cand0;
   logic [PM_W-1:0] cand1;
   logic [3:0]      sel;
   logic [1:0]      best;
   logic [PM_W-1:0] best_pm;

   function automatic logic [1:0] ham(
      input logic [1:0] a,
      input logic [1:0] b
   );
      logic [1:0] x;
      x = a ^ b;
      return {1'b0, x[1]} + {1'b0, x[0]};
   endfunction

   function automatic logic [PM_W-1:0] sat_add(
      input logic [PM_W-1:0] a,
      input logic [1:0]      d
   );
      logic [PM_W:0] s;
      s = {1'b0, a} + {{(PM_W-1){1'b0}}, d};
      return (s > {1'b0, PM_MAX}) ? PM_MAX : s[PM_W-1:0];
   endfunction

   // Next state {u,s1} is reached from {s1,0} or {s1,1}; the s2=1
   // branch output is the complement of the s2=0 branch output.
   always_comb begin
      rx      = frame[2*(FRAME_SYMS-1-int'(idx)) +: 2];
      ns      = '0;
      e0      = '0;
      e1      = '0;
      cand0   = '0;
      cand1   = '0;
      sel     = '0;
      for (int n = 0; n < 4; n++) begin
         pm_nxt[n] = '0;
      end
      for (int n = 0; n < 4; n++) begin
         ns        = 2'(n);
         e0        = {ns[1] ^ ns[0], ns[1]};
         e1        = ~e0;
         cand0     = sat_add(pm[{ns[0], 1'b0}], ham(rx, e0));
         cand1     = sat_add(pm[{ns[0], 1'b1}], ham(rx, e1));
         sel[n]    = (cand1 < cand0);
         pm_nxt[n] = sel[n] ? cand1 : cand0;
      end
      best    = '0;
      best_pm = pm_nxt[0];
      for (int i = 1; i < 4; i++) begin
         if (pm_nxt[i] < best_pm) begin
            best    = 2'(i);
            best_pm = pm_nxt[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= LOAD;
         data_out <= '0;
         frame    <= '0;
         idx      <= '0;
         tb_state <= '0;
         dec      <= '0;
         pm[0]    <= '0;
         for (int n = 1; n < 4; n++) begin
            pm[n] <= PM_MAX;
         end
         for (int n = 0; n < 4; n++) begin
            surv[n] <= '0;
         end
      end else begin
         unique case (state)
            LOAD: begin
               frame <= data_in;
               pm[0] <= '0;
               for (int n = 1; n < 4; n++) begin
                  pm[n] <= PM_MAX;
               end
               idx   <= '0;
               state <= ACS;
            end
            ACS: begin
               for (int n = 0; n < 4; n++) begin
                  pm[n]        <= pm_nxt[n];
                  surv[n][idx] <= sel[n];
               end
               if (idx == LAST_IX) begin
                  tb_state <= best;
                  state    <= TRACEBACK;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            TRACEBACK: begin
               // Decoded bit is s1 of the current state; first step
               // (last symbol) ends up in the LSB after all shifts.
               dec      <= {tb_state[1], dec[FRAME_SYMS-1:1]};
               tb_state <= {tb_state[0], surv[tb_state][idx]};
               if (idx == '0) begin
                  state <= OUTPUT;
               end else begin
                  idx <= idx - 1'b1;
               end
            end
            OUTPUT: begin
               data_out <= dec;
               state    <= LOAD;
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_viterbi_decoder_top.sv
// Directed self-checking bench for viterbi_decoder_top.
// Edge e counts rising edges since reset release; LOAD edges at e%18==0.
module tb_viterbi_decoder_top;

   logic        clk;
   logic        rst;
   logic [15:0] data_in;
   logic [7:0]  data_out;

   int n_assert;
   int n_fail;
   int e;
   int base;
   int idx;
   logic [15:0] word;
   logic [15:0] frames [3];
   logic [7:0]  seq    [4];

   viterbi_decoder_top dut (
      .clk      (clk),
      .rst      (rst),
      .data_in  (data_in),
      .data_out (data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic goto(input int t);
      while (e < t) begin
         @(posedge clk);
         #1;
         e++;
      end
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      e        = -1;
      rst      = 1'b0;
      data_in  = 16'h0000;
      frames[0] = 16'hE170;
      frames[1] = 16'hDAAA;
      frames[2] = 16'h0000;
      seq[0] = 8'h00;
      seq[1] = 8'hB0;
      seq[2] = 8'hFF;
      seq[3] = 8'h00;

      @(posedge clk);
      #1;
      chk("reset_c1", data_out, 8'h00);
      @(posedge clk);
      #1;
      chk("reset_c2", data_out, 8'h00);
      rst = 1'b1;

      goto(16);
      chk("post_reset_idle", data_out, 8'h00);
      goto(18);
      chk("first_output_zero", data_out, 8'h00);

      data_in = 16'hE170;
      goto(52);
      chk("b0_not_early", data_out, 8'h00);
      goto(54);
      chk("b0_decode", data_out, 8'hB0);
      goto(60);
      chk("b0_stable", data_out, 8'hB0);

      data_in = 16'hDAAA;
      goto(73);
      data_in = 16'h1234;
      goto(88);
      chk("b0_before_ff", data_out, 8'hB0);
      data_in = 16'hDAAA;
      goto(90);
      chk("ff_decode_glitch_ignored", data_out, 8'hFF);

      base = 90;
      for (int k = 15; k >= 0; k--) begin
         word    = 16'hE170 ^ (16'h0001 << k);
         data_in = word;
         goto(base + 36);
         chk($sformatf("single_err_bit%0d", k), data_out, 8'hB0);
         base = base + 36;
      end

      data_in = 16'h0000;
      goto(base + 36);
      chk("stream_pre_zero", data_out, 8'h00);
      base = base + 36;

      idx = 0;
      for (int f = 0; f < 3; f++) begin
         data_in = frames[f];
         for (int c = 0; c < ((f == 2) ? 46 : 26); c++) begin
            goto(e + 1);
            if (idx < 3 && data_out === seq[idx+1]) idx++;
            chk($sformatf("stream_f%0d_c%0d", f, c), data_out, seq[idx]);
         end
      end
      chk("stream_reached_end", 8'(idx), 8'd3);

      data_in = 16'hDAAA;
      base = ((e / 18) + 2) * 18;
      goto(base + 12);
      chk("ff_before_reset", data_out, 8'hFF);
      goto(base + 18 + 3);
      rst = 1'b0;
      goto(e + 1);
      chk("midreset_clear", data_out, 8'h00);
      rst = 1'b1;
      e   = -1;
      goto(16);
      chk("midreset_no_partial", data_out, 8'h00);
      goto(18);
      chk("midreset_redecode", data_out, 8'hFF);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
